mmcm_drp_responder: RTL
=======================

Name: mmcm_drp_responder

Overview:
Synthesizable and simulatable model of the MMCME2/PLLE2 dynamic reconfiguration port (DRP) slave side. It answers DEN/DWE/DADDR/DI transactions with DRDY/DO after a fixed latency and holds the MMCM configuration register file. It emulates LOCKED behaviour around the MMCM RST input. It stands in for the hard primitive so that the reconfiguration initiator can be exercised in simulation and on-chip loopback tests. It also exposes decoded CLKOUT0/CLKFBOUT/DIVCLK fields for checking.

Parameters:
LATENCY, 4, cycles from DEN sample to DRDY pulse; legal range 1..15.
LOCK_CYCLES, 64, cycles after mmcm_rst deasserts before locked rises; must be ≥1.

Ports:
clk  input  1  single clock; DRP and all state are synchronous to it
rst_n  input  1  asynchronous, active-low reset
den  input  1  DRP enable, one-cycle strobe
dwe  input  1  DRP write enable, qualified by den
daddr  input  7  DRP address
di  input  16  DRP write data
drp_do  output  16  DRP read data; valid only while drdy=1, otherwise 0
drdy  output  1  one-cycle completion pulse
mmcm_rst  input  1  emulated MMCM RST, active-high
locked  output  1  emulated LOCKED
busy  output  1  transaction outstanding
protocol_err  output  1  sticky; set on DEN while busy
err_clr  input  1  clears protocol_err
clkout0_high, clkout0_low, clkfbout_high, clkfbout_low  output  6 each  decoded HIGH_TIME/LOW_TIME fields
clkout0_phase_mux  output  3  decoded PHASE_MUX
divclk_no_count, divclk_edge  output  1 each  decoded DIVCLK bits

Behaviour:
- Reset (rst_n=0, asynchronous): drp_do=0, drdy=0, busy=0, protocol_err=0, locked=0, counters=0.
- Register reset values: all implemented registers are 0, except 0x16 = 16'h1041 (NO_COUNT=1, HIGH=1, LOW=1).
- Implemented addresses: 0x06–0x16, 0x18–0x1A, 0x28, 0x4E, 0x4F.
- Unimplemented addresses read 16'h0000 and ignore writes; they still complete with drdy.
- FSM IDLE -> WAIT -> DONE -> IDLE.
  - IDLE: when den=1, capture daddr, dwe and di, load cnt=LATENCY-1, set busy=1, go to WAIT. With LATENCY=1, go straight to DONE.
  - WAIT: decrement cnt; at 0 go to DONE.
  - DONE: drdy=1 for exactly one cycle. A write commits to the register in this cycle. A read returns the register value as of this cycle. busy=0 next cycle, return to IDLE.
- Timing: drdy rises exactly LATENCY cycles after the den sample edge. A new den is accepted in the cycle following drdy.
- den while busy, or in the DONE cycle: ignored, protocol_err set. The transaction in flight is unaffected.
- err_clr together with a new error in the same cycle: the error wins, protocol_err stays 1.
- Field layout (ClkReg1):
  - [15:13] PHASE_MUX, [11:6] HIGH_TIME, [5:0] LOW_TIME.
  - CLKOUT0 ClkReg1 = 0x08. CLKFBOUT ClkReg1 = 0x14.
  - DIVCLK = 0x16: [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW.
  - Decoded outputs are combinational from register flops.
- LOCKED:
  - While mmcm_rst=1: locked=0 and lock counter=0.
  - After the falling edge of mmcm_rst: locked rises after LOCK_CYCLES clocks.
  - Any DRP write while mmcm_rst=0 forces locked=0 and restarts the lock count. This flags an initiator that reconfigures without holding RST.
- Reset mid-transaction: everything returns to reset values, the pending write is dropped, and no drdy is issued.

Decomposition:
- Package mmcm_drp_pkg holds:
  - address constants (CLKOUT0_REG1=7'h08, CLKOUT0_REG2=7'h09, CLKFBOUT_REG1=7'h14, CLKFBOUT_REG2=7'h15, DIVCLK_REG=7'h16, LOCK_REG1..3=7'h18..1A, POWER_REG=7'h28, FILT_REG1/2=7'h4E/4F);
  - a reset-value function;
  - an is_implemented(addr) function;
  - field bit-range constants.
- One sub-module, mmcm_drp_regfile: implemented-register storage with async reset, write port and combinational read mux.

Test Plan:
- Reset, then read 0x16 -> drdy exactly 4 cycles after den, drp_do=16'h1041. Read 0x08 -> 16'h0000.
- Write 0x08=16'h028A, then read back -> drp_do=16'h028A; clkout0_high=10, clkout0_low=10, phase_mux=0.
- Write 0x16=16'h1041, 0x14=16'h028A; write 0x30=16'hFFFF, then read 0x30 -> 0x30 read returns 0; decoded fields unchanged by the 0x30 write; divclk_no_count=1.
- den asserted on cycles 0 and 2 (LATENCY=4) -> single drdy at cycle 4, protocol_err=1. err_clr -> protocol_err=0 next cycle.
- Locked sequence:
  - mmcm_rst high 10 cycles, then low -> locked=1 exactly 64 cycles later.
  - Write with mmcm_rst=0 -> locked=0 in the commit cycle, recount 64.
- rst_n pulsed low during WAIT of a write to 0x09 -> no drdy; 0x09 reads 0 afterwards.

Source files
------------

// File: rtl/mmcm_drp_pkg.sv
// Shared constants, types and helpers for the MMCM DRP responder model.
package mmcm_drp_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 16;
  localparam int NUM_ADDR = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] CLKOUT0_REG1  = 7'h08;
  localparam logic [ADDR_W-1:0] CLKOUT0_REG2  = 7'h09;
  localparam logic [ADDR_W-1:0] CLKFBOUT_REG1 = 7'h14;
  localparam logic [ADDR_W-1:0] CLKFBOUT_REG2 = 7'h15;
  localparam logic [ADDR_W-1:0] DIVCLK_REG    = 7'h16;
  localparam logic [ADDR_W-1:0] LOCK_REG1     = 7'h18;
  localparam logic [ADDR_W-1:0] LOCK_REG2     = 7'h19;
  localparam logic [ADDR_W-1:0] LOCK_REG3     = 7'h1A;
  localparam logic [ADDR_W-1:0] POWER_REG     = 7'h28;
  localparam logic [ADDR_W-1:0] FILT_REG1     = 7'h4E;
  localparam logic [ADDR_W-1:0] FILT_REG2     = 7'h4F;

  // First address of the contiguous clock-output block ending at DIVCLK_REG
  localparam logic [ADDR_W-1:0] CLKBLK_FIRST  = 7'h06;

  localparam logic [DATA_W-1:0] DIVCLK_RST    = 16'h1041;

  localparam int PMUX_MSB      = 15;
  localparam int PMUX_LSB      = 13;
  localparam int HIGH_MSB      = 11;
  localparam int HIGH_LSB      = 6;
  localparam int LOW_MSB       = 5;
  localparam int LOW_LSB       = 0;
  localparam int DIV_EDGE_BIT  = 13;
  localparam int DIV_NOCNT_BIT = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } drp_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drp_req_t;

  function automatic logic is_implemented(input logic [ADDR_W-1:0] a);
    return ((a >= CLKBLK_FIRST) && (a <= DIVCLK_REG)) ||
           ((a >= LOCK_REG1) && (a <= LOCK_REG3)) ||
           (a == POWER_REG) || (a == FILT_REG1) || (a == FILT_REG2);
  endfunction

  function automatic logic [DATA_W-1:0] reset_value(input logic [ADDR_W-1:0] a);
    return (a == DIVCLK_REG) ? DIVCLK_RST : '0;
  endfunction

endpackage

// File: rtl/mmcm_drp_regfile.sv
// Sparse DRP register file: flops exist only at implemented addresses,
// everything else reads as zero and swallows writes.
module mmcm_drp_regfile
  import mmcm_drp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] clkout0_reg1,
  output logic [DATA_W-1:0] clkfbout_reg1,
  output logic [DATA_W-1:0] divclk_reg
);

  logic [DATA_W-1:0] regs [NUM_ADDR];

  for (genvar a = 0; a < NUM_ADDR; a++) begin : g_reg
    localparam logic [ADDR_W-1:0] A = ADDR_W'(a);
    if (is_implemented(A)) begin : g_impl
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  q <= reset_value(A);
        else if (we && (waddr == A)) q <= wdata;
      end
      assign regs[a] = q;
    end else begin : g_none
      assign regs[a] = '0;
    end
  end

  assign rdata         = regs[raddr];
  assign clkout0_reg1  = regs[CLKOUT0_REG1];
  assign clkfbout_reg1 = regs[CLKFBOUT_REG1];
  assign divclk_reg    = regs[DIVCLK_REG];

endmodule

// File: rtl/mmcm_drp_responder.sv
// DRP slave stand-in for MMCME2/PLLE2: fixed-latency DRDY, register file,
// LOCKED emulation around RST, and decoded clock fields for checking.
module mmcm_drp_responder
  import mmcm_drp_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              den,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] drp_do,
  output logic              drdy,
  input  logic              mmcm_rst,
  output logic              locked,
  output logic              busy,
  output logic              protocol_err,
  input  logic              err_clr,
  output logic [5:0]        clkout0_high,
  output logic [5:0]        clkout0_low,
  output logic [5:0]        clkfbout_high,
  output logic [5:0]        clkfbout_low,
  output logic [2:0]        clkout0_phase_mux,
  output logic              divclk_no_count,
  output logic              divclk_edge
);

  localparam logic [3:0]     CNT_LOAD = 4'(LATENCY - 1);
  localparam int             LCW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

  drp_state_e        state, state_n;
  logic [3:0]        cnt, cnt_n;
  drp_req_t          req, req_n;
  logic              err_set;
  logic              commit;
  logic [LCW-1:0]    lock_cnt;
  logic [DATA_W-1:0] rdata, co0_reg, cfb_reg, div_reg;
  logic              unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req   <= req_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    err_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (den) begin
          req_n   = '{we: dwe, addr: daddr, data: di};
          cnt_n   = CNT_LOAD;
          state_n = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        err_set = den;
        cnt_n   = cnt - 4'd1;
        if (cnt_n == 4'd0) state_n = ST_DONE;
      end
      ST_DONE: begin
        err_set = den;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign drdy   = (state == ST_DONE);
  assign busy   = (state != ST_IDLE);
  assign commit = drdy && req.we;
  assign drp_do = drdy ? rdata : '0;

  // A new violation outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       protocol_err <= 1'b0;
    else if (err_set) protocol_err <= 1'b1;
    else if (err_clr) protocol_err <= 1'b0;
  end

  // Writes while running act like a fresh RST release so the initiator
  // that forgets to hold RST sees LOCKED drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   lock_cnt <= '0;
    else if (mmcm_rst || commit)  lock_cnt <= '0;
    else if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
  end

  assign locked = !mmcm_rst && !commit && (lock_cnt == LOCK_MAX);

  mmcm_drp_regfile u_regfile (
    .clk           (clk),
    .rst_n         (rst_n),
    .we            (commit),
    .waddr         (req.addr),
    .wdata         (req.data),
    .raddr         (req.addr),
    .rdata         (rdata),
    .clkout0_reg1  (co0_reg),
    .clkfbout_reg1 (cfb_reg),
    .divclk_reg    (div_reg)
  );

  assign clkout0_high      = co0_reg[HIGH_MSB:HIGH_LSB];
  assign clkout0_low       = co0_reg[LOW_MSB:LOW_LSB];
  assign clkout0_phase_mux = co0_reg[PMUX_MSB:PMUX_LSB];
  assign clkfbout_high     = cfb_reg[HIGH_MSB:HIGH_LSB];
  assign clkfbout_low      = cfb_reg[LOW_MSB:LOW_LSB];
  assign divclk_no_count   = div_reg[DIV_NOCNT_BIT];
  assign divclk_edge       = div_reg[DIV_EDGE_BIT];

  assign unused_bits = ^{co0_reg[12], cfb_reg[15:12], div_reg[15:14], div_reg[11:0]};

endmodule
